// File: rtl/dff_stim_gen.sv
// Stimulus generator and self-checker for a bank of DFFARX1-class flops.
// Drives reset-qualified pseudo-random D, models expected Q, counts mismatches and D toggles.
module dff_stim_gen #(
    parameter int unsigned N       = 8,
    parameter int unsigned RST_LEN = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          START,
    input  logic [15:0]   NCYC,
    input  logic [15:0]   SEED,
    output logic [N-1:0]  D_OUT,
    output logic          RSTB_OUT,
    input  logic [N-1:0]  Q_IN,
    input  logic [N-1:0]  QN_IN,
    output logic          BUSY,
    output logic          DONE,
    output logic          PASS,
    output logic [15:0]   ERR_CNT,
    output logic [23:0]   TOGGLE_CNT
);

    localparam logic [15:0] LFSR_MASK  = 16'hB400;
    localparam logic [15:0] SEED_DFLT  = 16'hACE1;
    localparam int unsigned POP_W      = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RSTP,
        S_REC,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state;
    logic [15:0]     lfsr;
    logic [15:0]     lfsr_nxt;
    logic [15:0]     cnt;
    logic [15:0]     ncyc_q;
    logic [N-1:0]    exp_q;
    logic [N-1:0]    d_prev;
    logic [N-1:0]    d_diff;
    logic [POP_W-1:0] pop;
    logic [24:0]     tog_sum;
    logic [23:0]     tog_nxt;
    logic [15:0]     err_nxt;
    logic            chk_en;
    logic            mism;
    logic            rstb_nxt;

    // Galois right-shift step, taps x^16+x^14+x^13+x^11+1
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        lfsr_step = v[0] ? ((v >> 1) ^ LFSR_MASK) : (v >> 1);
    endfunction

    // Next LFSR value, checker, toggle accumulation and reset pin value
    always_comb begin
        lfsr_nxt = lfsr_step(lfsr);
        rstb_nxt = (state != S_RSTP);
        chk_en   = (state == S_REC) || (state == S_RUN) || (state == S_DRAIN);
        // Case inequality so X/Z on the flop outputs is a mismatch
        mism     = (Q_IN !== exp_q) || (QN_IN !== ~Q_IN);
        err_nxt  = ERR_CNT;
        if (chk_en && mism && (ERR_CNT != 16'hFFFF)) begin
            err_nxt = ERR_CNT + 16'd1;
        end

        d_diff = D_OUT ^ d_prev;
        pop    = '0;
        for (int i = 0; i < int'(N); i++) begin
            pop = pop + POP_W'(d_diff[i]);
        end
        tog_sum = {1'b0, TOGGLE_CNT} + 25'(pop);
        tog_nxt = TOGGLE_CNT;
        if ((state == S_RUN) || (state == S_DRAIN)) begin
            tog_nxt = tog_sum[24] ? 24'hFFFFFF : tog_sum[23:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= S_IDLE;
            lfsr       <= SEED_DFLT;
            cnt        <= '0;
            ncyc_q     <= '0;
            exp_q      <= '0;
            d_prev     <= '0;
            D_OUT      <= '0;
            RSTB_OUT   <= 1'b0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            PASS       <= 1'b0;
            ERR_CNT    <= '0;
            TOGGLE_CNT <= '0;
        end else begin
            d_prev     <= D_OUT;
            // Flop is reset-dominant: Q is 0 if RSTB is low before or after the edge
            exp_q      <= (!rstb_nxt || !RSTB_OUT) ? '0 : D_OUT;
            RSTB_OUT   <= rstb_nxt;
            ERR_CNT    <= err_nxt;
            TOGGLE_CNT <= tog_nxt;
            DONE       <= 1'b0;

            case (state)
                S_IDLE: begin
                    D_OUT <= '0;
                    if (START) begin
                        state      <= S_RSTP;
                        ncyc_q     <= NCYC;
                        lfsr       <= (SEED == 16'h0000) ? SEED_DFLT : SEED;
                        cnt        <= 16'(RST_LEN - 1);
                        ERR_CNT    <= '0;
                        TOGGLE_CNT <= '0;
                        PASS       <= 1'b0;
                        BUSY       <= 1'b1;
                    end
                end
                S_RSTP: begin
                    D_OUT <= '0;
                    if (cnt == 16'd0) begin
                        state <= S_REC;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                S_REC: begin
                    D_OUT <= '0;
                    if (ncyc_q == 16'd0) begin
                        state <= S_DRAIN;
                        cnt   <= 16'd1;
                    end else begin
                        state <= S_RUN;
                        cnt   <= ncyc_q;
                    end
                end
                S_RUN: begin
                    lfsr  <= lfsr_nxt;
                    D_OUT <= lfsr_nxt[N-1:0];
                    if (cnt == 16'd1) begin
                        state <= S_DRAIN;
                        cnt   <= 16'd1;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                S_DRAIN: begin
                    if (cnt == 16'd0) begin
                        state <= S_DONE;
                        DONE  <= 1'b1;
                        BUSY  <= 1'b0;
                        PASS  <= (err_nxt == 16'd0);
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                S_DONE: begin
                    D_OUT <= '0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dff_stim_gen.sv
// Bench for dff_stim_gen: behavioural flop bank with fault modes, table of runs,
// D_OUT scoreboard queue and hand-written reset/START corner sequences.
module tb_dff_stim_gen;

    localparam int unsigned N       = 8;
    localparam int unsigned RST_LEN = 4;

    logic          CLK;
    logic          RST;
    logic          START;
    logic [15:0]   NCYC;
    logic [15:0]   SEED;
    logic [N-1:0]  D_OUT;
    logic          RSTB_OUT;
    logic [N-1:0]  Q_IN;
    logic [N-1:0]  QN_IN;
    logic          BUSY;
    logic          DONE;
    logic          PASS;
    logic [15:0]   ERR_CNT;
    logic [23:0]   TOGGLE_CNT;

    dff_stim_gen #(.N(N), .RST_LEN(RST_LEN)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .START      (START),
        .NCYC       (NCYC),
        .SEED       (SEED),
        .D_OUT      (D_OUT),
        .RSTB_OUT   (RSTB_OUT),
        .Q_IN       (Q_IN),
        .QN_IN      (QN_IN),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .PASS       (PASS),
        .ERR_CNT    (ERR_CNT),
        .TOGGLE_CNT (TOGGLE_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Flop bank under test: async active-low reset DFF; fault 1 = Q[2] stuck 1, fault 2 = QN tied to Q
    int           fault_mode = 0;
    logic [N-1:0] fq;
    logic [N-1:0] q_bank;
    always_ff @(posedge CLK or negedge RSTB_OUT) begin
        if (!RSTB_OUT) fq <= '0;
        else           fq <= D_OUT;
    end
    assign q_bank = (fault_mode == 1) ? (fq | 8'h04) : fq;
    assign Q_IN   = q_bank;
    assign QN_IN  = (fault_mode == 2) ? q_bank : ~q_bank;

    int n_chk  = 0;
    int n_pass = 0;
    logic [7:0] d_exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [15:0] step(input logic [15:0] v);
        logic [15:0] s;
        s = v >> 1;
        if (v[0]) s = s ^ 16'hB400;
        return s;
    endfunction

    typedef struct {
        logic [15:0] seed;
        logic [15:0] ncyc;
        int          mode;
        bit          restart;
        int          exp_done_k;
        bit          exp_pass;
        int          exp_err;   // -1: taken from the reference model
    } tcase_t;

    tcase_t tbl[6];

    task automatic run_case(input tcase_t tc);
        int          n;
        int          done_k;
        int          m_err;
        int          m_tog;
        int          e_err;
        logic [15:0] l;
        logic [7:0]  v[$];
        logic [7:0]  e[$];
        logic [7:0]  last;
        logic [7:0]  dexp;
        n      = int'(tc.ncyc);
        done_k = tc.exp_done_k;

        // Reference D sequence, expected-Q sequence per check cycle, toggles and errors
        v.delete(); e.delete(); d_exp_q.delete();
        v.push_back(8'h00);
        l = (tc.seed == 16'h0000) ? 16'hACE1 : tc.seed;
        for (int i = 0; i < n; i++) begin
            l = step(l);
            v.push_back(l[7:0]);
            d_exp_q.push_back(l[7:0]);
        end
        m_tog = 0;
        for (int i = 1; i <= n; i++) m_tog += $countones(v[i] ^ v[i-1]);
        e.push_back(8'h00);
        for (int j = 1; j <= n; j++) e.push_back((j >= 3) ? v[j-2] : 8'h00);
        e.push_back((n >= 1) ? v[n-1] : 8'h00);
        e.push_back(v[n]);
        m_err = 0;
        if (tc.mode == 1) begin
            foreach (e[i]) if (!e[i][2]) m_err++;
        end else if (tc.mode == 2) begin
            m_err = e.size();
        end
        e_err = (tc.exp_err >= 0) ? tc.exp_err : m_err;
        last  = v[n];

        @(negedge CLK);
        fault_mode = tc.mode;
        START = 1'b1;
        NCYC  = tc.ncyc;
        SEED  = tc.seed;
        @(posedge CLK);
        for (int k = 0; k <= done_k + 1; k++) begin
            @(negedge CLK);
            if (k == 0) START = 1'b0;
            if (tc.restart && k == 3) begin
                START = 1'b1;
                NCYC  = 16'd1;
                SEED  = 16'h0000;
            end
            if (tc.restart && k == 4) START = 1'b0;

            chk("busy", 32'(BUSY), 32'(k < done_k));
            chk("done", 32'(DONE), 32'(k == done_k));
            if (k <= done_k) begin
                chk("rstb", 32'(RSTB_OUT), 32'(!(k >= 1 && k <= int'(RST_LEN))));
                if (k < int'(RST_LEN) + 2) begin
                    chk("d_idle", 32'(D_OUT), 32'h0);
                end else if (k <= int'(RST_LEN) + 1 + n) begin
                    if (d_exp_q.size() == 0) begin
                        chk("d_queue_empty", 32'(d_exp_q.size()), 32'd1);
                    end else begin
                        dexp = d_exp_q.pop_front();
                        chk("d_run", 32'(D_OUT), 32'(dexp));
                    end
                end else begin
                    chk("d_hold", 32'(D_OUT), 32'(last));
                end
            end
            if (k == done_k) begin
                chk("pass", 32'(PASS), 32'(tc.exp_pass));
                chk("err_cnt", 32'(ERR_CNT), 32'(e_err));
                chk("toggle_cnt", 32'(TOGGLE_CNT), 32'(m_tog));
            end
        end
        chk("d_queue_drained", 32'(d_exp_q.size()), 32'd0);
    endtask

    initial begin
        int saw_done;
        tbl[0] = '{16'h0001, 16'd10, 0, 1'b0, 17, 1'b1, 0};
        tbl[1] = '{16'h0000, 16'd3,  0, 1'b0, 10, 1'b1, 0};
        tbl[2] = '{16'h1234, 16'd5,  1, 1'b0, 12, 1'b0, -1};
        tbl[3] = '{16'h00FF, 16'd4,  2, 1'b0, 11, 1'b0, 7};
        tbl[4] = '{16'h5555, 16'd0,  0, 1'b0, 7,  1'b1, 0};
        tbl[5] = '{16'hBEEF, 16'd20, 0, 1'b1, 27, 1'b1, 0};

        RST = 1'b1; START = 1'b0; NCYC = '0; SEED = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_d",    32'(D_OUT),      32'h0);
        chk("rst_rstb", 32'(RSTB_OUT),   32'h0);
        chk("rst_busy", 32'(BUSY),       32'h0);
        chk("rst_done", 32'(DONE),       32'h0);
        chk("rst_pass", 32'(PASS),       32'h0);
        chk("rst_err",  32'(ERR_CNT),    32'h0);
        chk("rst_tog",  32'(TOGGLE_CNT), 32'h0);
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        chk("idle_rstb", 32'(RSTB_OUT), 32'h1);

        for (int t = 0; t < 6; t++) run_case(tbl[t]);

        // START together with RST is ignored
        fault_mode = 0;
        @(negedge CLK);
        RST = 1'b1; START = 1'b1; NCYC = 16'd5; SEED = 16'h0001;
        @(negedge CLK);
        RST = 1'b0; START = 1'b0;
        repeat (2) @(negedge CLK);
        chk("start_in_rst_busy", 32'(BUSY), 32'h0);

        // Abort 3 cycles into RUN: outputs return to reset values, no DONE follows
        START = 1'b1; NCYC = 16'd10; SEED = 16'h0001;
        @(posedge CLK);
        @(negedge CLK);
        START = 1'b0;
        repeat (int'(RST_LEN) + 4) @(negedge CLK);
        chk("abort_busy_before", 32'(BUSY), 32'h1);
        RST = 1'b1;
        @(negedge CLK);
        chk("abort_d",    32'(D_OUT),    32'h0);
        chk("abort_rstb", 32'(RSTB_OUT), 32'h0);
        chk("abort_busy", 32'(BUSY),     32'h0);
        chk("abort_done", 32'(DONE),     32'h0);
        RST = 1'b0;
        saw_done = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge CLK);
            if (DONE) saw_done++;
        end
        chk("abort_no_done", 32'(saw_done), 32'd0);

        run_case(tbl[0]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dff_stim_gen.md
# dff_stim_gen

Stimulus generator and self-checker that drives the D and RSTB pins of a bank of DFFARX1-class flops under test and checks their Q/QN outputs. It produces pseudo-random, reset-qualified D activity for power characterisation runs. It also counts input toggles for activity normalisation and flags functional mismatches. It sits between the test-power run controller and the instantiated flop bank, and shares the flop bank's clock.

## Interface

Parameters:
- N, 8: number of flops under test, 1..16.
- RST_LEN, 4: cycles RSTB_OUT is held low at run start, at least 1.

Ports:
- CLK  in  1  clock, shared with the DUT flops.
- RST  in  1  synchronous, active-high reset.
- START  in  1  one-cycle run request, sampled only in IDLE.
- NCYC  in  16  number of RUN cycles, latched at START.
- SEED  in  16  LFSR seed, latched at START. 0 is replaced by 16'hACE1.
- D_OUT  out  N  drives the DUT D pins, registered.
- RSTB_OUT  out  1  drives the DUT RSTB pins, registered, active low.
- Q_IN  in  N  DUT Q pins.
- QN_IN  in  N  DUT QN pins.
- BUSY  out  1  high from the START edge until DONE.
- DONE  out  1  one-cycle pulse at the end of a run.
- PASS  out  1  ERR_CNT==0 at DONE; held until the next START.
- ERR_CNT  out  16  count of mismatching check cycles, saturating.
- TOGGLE_CNT  out  24  total D_OUT bit toggles during the run, saturating.

## Operation

Reset values (RST high at an edge):
- State IDLE, D_OUT=0, RSTB_OUT=0, BUSY=0, DONE=0, PASS=0, ERR_CNT=0, TOGGLE_CNT=0.
- RST mid-run aborts the run immediately. No DONE is generated.

FSM:
- IDLE: RSTB_OUT=1 and D_OUT=0. START moves to RSTP, latches NCYC and SEED, clears ERR_CNT, TOGGLE_CNT and PASS, and sets BUSY.
- RSTP: RSTB_OUT=0 and D_OUT=0 for RST_LEN cycles, then REC.
- REC: one cycle with RSTB_OUT=1 and D_OUT=0. This is the recovery gap before D activity starts. Goes to RUN, or to DRAIN if NCYC==0.
- RUN: NCYC cycles. Each cycle the LFSR advances once and D_OUT is loaded with lfsr[N-1:0]. Then DRAIN.
- DRAIN: 2 cycles with D_OUT held, checks continue. Then DONE.
- DONE: DONE=1, BUSY=0, PASS registered. Returns to IDLE on the next edge.

LFSR:
- 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1, shift right. Feedback mask 16'hB400 is applied when lfsr[0]=1.
- Loaded with the latched SEED on entry to RSTP.

Expected model (exp_q, N bits, registered):
- exp_q_next = 0 if RSTB_OUT_next==0 or RSTB_OUT==0; otherwise D_OUT.
- This models the flop's reset-dominant behaviour. At the edge where RSTB rises, the DUT still sees RSTB low, so Q stays 0.

Checker:
- Enabled in REC, RUN and DRAIN.
- A cycle mismatches if Q_IN != exp_q, or QN_IN != ~Q_IN.
- Each mismatching cycle adds +1 to ERR_CNT (per cycle, not per bit). ERR_CNT saturates at 16'hFFFF.
- X/Z on Q_IN or QN_IN counts as a mismatch.

Toggle counter:
- Each cycle in RUN and DRAIN adds popcount(D_OUT ^ D_OUT_prev), where D_OUT_prev is D_OUT from the previous cycle.
- Saturates at 24'hFFFFFF.

## Timing

- All outputs are registered and there are no combinational paths from input to output.
- With START high at edge t0: BUSY=1 after t0. RSTB_OUT=0 after t0+1 through t0+RST_LEN. D_OUT's first random value appears after t0+RST_LEN+2.
- DONE is high for exactly the one cycle after edge t0+RST_LEN+NCYC+3. With defaults this is edge t0+7+NCYC.
- The DUT captures D_OUT one edge after it is driven. exp_q therefore lags D_OUT by one cycle, and Q_IN is compared at the following edge.
- START while BUSY is ignored. START in the same cycle as RST is ignored.
- NCYC=16'hFFFF is legal. There is no wrap; RUN lasts exactly 65535 cycles.

## Test plan

- Defaults, ideal flop bank, SEED=16'h0001, NCYC=10 -> DONE pulse at START+17, PASS=1, ERR_CNT=0. The first D_OUT is 8'h00 because lfsr=16'hB400 after one step.
- SEED=0, NCYC=3 -> the LFSR uses 16'hACE1, D_OUT sequence matches the Galois model, and TOGGLE_CNT equals the model popcount sum.
- Q_IN bit 2 forced to 1 throughout the run, NCYC=5 -> ERR_CNT=1+RST_LEN... no: ERR_CNT counts the REC cycle plus every check cycle where exp_q[2]=0. PASS=0.
- QN_IN tied to Q_IN, NCYC=4 -> every check cycle mismatches, ERR_CNT=7, PASS=0.
- NCYC=0 -> REC goes directly to DRAIN, DONE at START+7, TOGGLE_CNT=0, PASS=1.
- RST asserted 3 cycles into RUN -> the next cycle has D_OUT=0, RSTB_OUT=0 and BUSY=0, no DONE; after RST drops, a new START completes normally.
